// File: rtl/cmd_seq_pkg.sv
// cmd_seq_pkg: FSM states, mode codes, FIFO entry layout and sizing
// constants shared by the command sequencer and its bench.
package cmd_seq_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_ACK, RUN, DRAIN, FINISH} state_t;
  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ENUM  = 2'd1;
  localparam logic [1:0] MODE_COUNT = 2'd2;
  localparam logic [1:0] MODE_UPD   = 2'd3;
  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 31;
  typedef struct packed {
    logic [1:0] mode;
    logic [3:0] len;
    logic [7:0] data;
  } cmd_t;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with registered occupancy; pushes are dropped
// when full and pops are ignored when empty.
module cmd_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic [AW:0]   o_level
);
  localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] P_ONE  = AW'(1);
  localparam logic [AW-1:0] P_LAST = AW'(DEPTH - 1);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_level;
  logic w_push, w_pop;
  assign w_push  = i_push && r_level != L_FULL;
  assign w_pop   = i_pop && r_level != '0;
  assign o_dout  = r_mem[r_rp];
  assign o_level = r_level;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      r_wp    <= w_push ? (r_wp == P_LAST ? '0 : r_wp + P_ONE) : r_wp;
      r_rp    <= w_pop ? (r_rp == P_LAST ? '0 : r_rp + P_ONE) : r_rp;
      r_level <= (w_push && !w_pop) ? r_level + L_ONE :
                 (w_pop && !w_push) ? r_level - L_ONE : r_level;
    end
endmodule

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: queues {mode,len,data} commands and plays each one onto a
// downstream controller. Define CMD_SEQ_TIMEOUT_EN to add a WAIT_ACK/DRAIN watchdog.
module cmd_sequencer
  import cmd_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_len,
  input  logic [7:0] cmd_data,
  output logic [7:0] x,
  output logic [1:0] on,
  output logic       start,
  input  logic [1:0] regime,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] fifo_level
);
`ifdef CMD_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  state_t r_state;
  logic [1:0] r_mode;
  logic [3:0] r_cnt;
  logic [4:0] r_wd;
  cmd_t w_head;
  logic w_push, w_pop, w_to;
  assign cmd_ready = fifo_level != 3'(FIFO_DEPTH);
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = r_state == IDLE && fifo_level != 3'd0;
  assign w_to      = TO_EN && r_wd == 5'(TIMEOUT_CYC);
  cmd_fifo #(.W($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({cmd_mode, cmd_len, cmd_data}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_level (fifo_level)
  );
  // r_wd is reloaded to 1 on entry to each waiting state, so it holds the cycle count in that state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_mode  <= MODE_OFF;
      r_cnt   <= '0;
      r_wd    <= '0;
      x       <= '0;
      on      <= '0;
      start   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      r_wd <= r_wd + 5'd1;
      unique case (r_state)
        IDLE:
          if (w_pop) begin
            if (w_head.mode == MODE_OFF) err <= 1'b1;
            else begin
              r_mode  <= w_head.mode;
              r_cnt   <= w_head.len;
              x       <= w_head.data;
              on      <= w_head.mode;
              busy    <= 1'b1;
              r_state <= LAUNCH;
            end
          end
        LAUNCH: begin
          on      <= MODE_OFF;
          r_wd    <= 5'd1;
          r_state <= WAIT_ACK;
        end
        WAIT_ACK:
          if (regime == r_mode) begin
            r_wd    <= 5'd1;
            start   <= r_cnt != 4'd0;
            r_state <= r_cnt != 4'd0 ? RUN : DRAIN;
          end else if (w_to) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        RUN:
          if (regime == MODE_OFF) begin
            start   <= 1'b0;
            done    <= 1'b1;
            r_state <= FINISH;
          end else if (r_cnt == 4'd1) begin
            start   <= 1'b0;
            r_wd    <= 5'd1;
            r_state <= DRAIN;
          end else r_cnt <= r_cnt - 4'd1;
        DRAIN:
          if (regime == MODE_OFF) begin
            done    <= 1'b1;
            r_state <= FINISH;
          end else if (w_to) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        FINISH: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: directed commands against a timeline model of the
// sequencer plus a reactive downstream controller; also builds with CMD_SEQ_TIMEOUT_EN.
module tb_cmd_sequencer;
`ifdef CMD_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_mode = '0, on, regime = '0;
  logic [3:0] cmd_len = '0;
  logic [7:0] cmd_data = '0, x;
  logic start, busy, done, err;
  logic [2:0] fifo_level;
  cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .x(x), .on(on), .start(start), .regime(regime), .busy(busy),
    .done(done), .err(err), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_bad = 0;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  typedef struct { logic [1:0] m; logic [3:0] l; logic [7:0] d; int c; } ent_t;
  ent_t mq[$];
  int cyc = 0;
  bit m_ready = 1'b1, chk_en = 1'b0;
  logic [1:0] e_on = '0;
  logic [7:0] e_x = '0;
  bit e_start = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
  int n_on = 0, n_start = 0, n_done = 0, n_err = 0;
  logic [7:0] xs[$];
  bit ds_en = 1'b1;
  int ack_dly = 1, ds_hold = 5;
  // model FIFO: an accepted command is stamped so it cannot be popped on its own push edge
  always @(posedge clk) begin
    ent_t ne;
    if (!rst && cmd_valid && m_ready) begin
      ne.m = cmd_mode; ne.l = cmd_len; ne.d = cmd_data; ne.c = cyc;
      mq.push_back(ne);
    end
  end
  // command timeline: each posedge sets what the outputs must be after that edge
  initial begin
    ent_t c;
    int k;
    bit ab;
    forever begin
      @(posedge clk);
      e_err = 1'b0;
      if (mq.size() != 0 && mq[0].c < cyc) begin
        c = mq.pop_front();
        if (c.m == 2'd0) e_err = 1'b1;
        else begin
          e_on = c.m; e_x = c.d; e_busy = 1'b1;
          @(posedge clk);
          e_on = '0;
          k = 0;
          do begin @(posedge clk); k++; end while (regime != c.m && !(TO_EN && k == 31));
          if (regime != c.m) begin
            e_err = 1'b1; e_busy = 1'b0;
          end else begin
            ab = 1'b0;
            if (c.l != 0) begin
              e_start = 1'b1;
              for (int i = 1; i <= int'(c.l); i++) begin
                @(posedge clk);
                if (regime == 2'd0) begin ab = 1'b1; break; end
              end
              e_start = 1'b0;
            end
            if (!ab) begin
              k = 0;
              do begin @(posedge clk); k++; end while (regime != 2'd0 && !(TO_EN && k == 31));
            end
            if (regime == 2'd0) begin
              e_done = 1'b1;
              @(posedge clk);
              e_done = 1'b0; e_busy = 1'b0;
            end else begin
              e_err = 1'b1; e_busy = 1'b0;
            end
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("on", 32'(on), 32'(e_on));
      chk("x", 32'(x), 32'(e_x));
      chk("start", 32'(start), 32'(e_start));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
      chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() != 4));
    end
    if (on != 2'd0) begin n_on++; xs.push_back(x); end
    n_start += int'(start);
    n_done  += int'(done);
    n_err   += int'(err);
    m_ready = mq.size() != 4;
    cyc++;
  end
  // downstream controller: acknowledges a requested mode, holds it, then returns to off
  initial begin
    logic [1:0] pend, m;
    pend = '0;
    forever begin
      @(negedge clk);
      if (!busy) pend = '0;
      if (on != 2'd0) pend = on;
      if (ds_en && pend != 2'd0) begin
        m = pend; pend = '0;
        repeat (ack_dly) @(posedge clk);
        #1 regime = m;
        repeat (ds_hold) @(posedge clk);
        #1 regime = '0;
      end
    end
  end
  task automatic push(input logic [1:0] m, input logic [3:0] l, input logic [7:0] d);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_mode = m; cmd_len = l; cmd_data = d;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (ok) @(posedge clk);
    else chk("push_accept", 32'(0), 32'(1));
    #1 cmd_valid = 1'b0;
  endtask
  task automatic settle();
    int q = 0;
    for (int t = 0; t < 400 && q < 3; t++) begin
      @(negedge clk);
      q = (!busy && fifo_level == 3'd0) ? q + 1 : 0;
    end
    if (q < 3) chk("settle", 32'(0), 32'(1));
    @(posedge clk);
    #1;
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int b_on, b_st, b_dn, b_er, bx;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 32'(x), 32'(0));
    chk("rst_on", 32'(on), 32'(0));
    chk("rst_start", 32'(start), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_level", 32'(fifo_level), 32'(0));
    chk("rst_ready", 32'(cmd_ready), 32'(1));
    @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    // one count command with len 3
    b_on = n_on; b_st = n_start; b_dn = n_done; b_er = n_err; bx = xs.size();
    push(2'd2, 4'd3, 8'hA5);
    settle();
    chk("a5_on_cycles", 32'(n_on - b_on), 32'(1));
    chk("a5_start_cycles", 32'(n_start - b_st), 32'(3));
    chk("a5_done", 32'(n_done - b_dn), 32'(1));
    chk("a5_err", 32'(n_err - b_er), 32'(0));
    chk("a5_x", 32'(xs[bx]), 32'(8'hA5));
    // illegal mode followed by a legal command
    b_on = n_on; b_st = n_start; b_dn = n_done; b_er = n_err; bx = xs.size();
    push(2'd0, 4'd2, 8'hEE);
    push(2'd1, 4'd2, 8'h3C);
    settle();
    chk("ill_err", 32'(n_err - b_er), 32'(1));
    chk("ill_on_cycles", 32'(n_on - b_on), 32'(1));
    chk("ill_next_x", 32'(xs[bx]), 32'(8'h3C));
    chk("ill_next_start", 32'(n_start - b_st), 32'(2));
    chk("ill_next_done", 32'(n_done - b_dn), 32'(1));
    // zero-length command goes straight to drain
    ds_hold = 2;
    b_st = n_start; b_dn = n_done;
    push(2'd3, 4'd0, 8'h5A);
    settle();
    chk("len0_start", 32'(n_start - b_st), 32'(0));
    chk("len0_done", 32'(n_done - b_dn), 32'(1));
    // regime drops mid-run: start cut short, still done, no err
    b_st = n_start; b_dn = n_done; b_er = n_err;
    push(2'd1, 4'd5, 8'hC3);
    settle();
    chk("abort_start", 32'(n_start - b_st), 32'(2));
    chk("abort_done", 32'(n_done - b_dn), 32'(1));
    chk("abort_err", 32'(n_err - b_er), 32'(0));
    // stalled downstream: fill the FIFO, hold the next push, then release in order
    ds_hold = 5; ds_en = 1'b0;
    b_dn = n_done; bx = xs.size();
    push(2'd1, 4'd1, 8'h11);
    push(2'd2, 4'd2, 8'h22);
    push(2'd3, 4'd0, 8'h33);
    push(2'd1, 4'd2, 8'h44);
    push(2'd2, 4'd1, 8'h55);
    @(negedge clk);
    chk("full_level", 32'(fifo_level), 32'(4));
    chk("full_ready", 32'(cmd_ready), 32'(0));
    fork
      push(2'd3, 4'd1, 8'h66);
      begin
        repeat (5) @(negedge clk);
        chk("held_level", 32'(fifo_level), 32'(4));
        chk("held_ready", 32'(cmd_ready), 32'(0));
        ds_en = 1'b1;
      end
    join
    settle();
    chk("stall_done", 32'(n_done - b_dn), 32'(6));
    chk("stall_cnt", 32'(xs.size() - bx), 32'(6));
    chk("order_0", 32'(xs[bx]), 32'(8'h11));
    chk("order_1", 32'(xs[bx+1]), 32'(8'h22));
    chk("order_2", 32'(xs[bx+2]), 32'(8'h33));
    chk("order_3", 32'(xs[bx+3]), 32'(8'h44));
    chk("order_4", 32'(xs[bx+4]), 32'(8'h55));
    chk("order_5", 32'(xs[bx+5]), 32'(8'h66));
    // downstream never acknowledges
    ds_en = 1'b0; ds_hold = 4;
    b_dn = n_done; b_er = n_err;
    push(2'd1, 4'd1, 8'h77);
    repeat (45) @(negedge clk);
    if (TO_EN) begin
      chk("to_err", 32'(n_err - b_er), 32'(1));
      chk("to_busy", 32'(busy), 32'(0));
      chk("to_done", 32'(n_done - b_dn), 32'(0));
    end else begin
      chk("noto_busy", 32'(busy), 32'(1));
      chk("noto_err", 32'(n_err - b_er), 32'(0));
    end
    ds_en = 1'b1;
    settle();
    chk("after_wait_done", 32'(n_done - b_dn), 32'(TO_EN ? 0 : 1));
    // reset in the middle of RUN with two commands queued
    ds_hold = 15;
    push(2'd2, 4'd10, 8'hD1);
    push(2'd2, 4'd10, 8'hD2);
    push(2'd2, 4'd10, 8'hD3);
    for (int t = 0; t < 50 && !start; t++) @(negedge clk);
    chk("run_reached", 32'(start), 32'(1));
    chk("run_level", 32'(fifo_level), 32'(2));
    chk_en = 1'b0;
    b_dn = n_done;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_start", 32'(start), 32'(0));
    chk("mid_rst_level", 32'(fifo_level), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_ready", 32'(cmd_ready), 32'(1));
    chk("mid_rst_x", 32'(x), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_rst_done", 32'(n_done - b_dn), 32'(0));
    chk("post_rst_busy", 32'(busy), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
